// File: rtl/pcs_pkg.sv
// Code-group constants and transmit state encoding for the 1000BASE-X PCS
// ordered-set generator.
package pcs_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;

  // Each state names the code-group driven while it is the current state.
  typedef enum logic [2:0] {
    ST_IDLE_K,
    ST_IDLE_D,
    ST_SOP,
    ST_DATA,
    ST_EOP_T,
    ST_EOP_R
  } pcs_state_e;

  function automatic logic state_is_busy(input pcs_state_e s);
    return (s == ST_SOP) || (s == ST_DATA) || (s == ST_EOP_T) || (s == ST_EOP_R);
  endfunction

endpackage

// File: rtl/pcs_tx_ordered_set.sv
// GMII-to-code-group ordered-set generator (/I/, /S/, /T/, /R/, optional /V/).
// Define PCS_TX_ERR_PROP_EN to replace errored data octets with /V/.
module pcs_tx_ordered_set (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txd,
  input  logic       tx_en,
  input  logic       tx_er,
  input  logic       rd,
  output logic [7:0] data,
  output logic       control,
  output logic       tx_even,
  output logic       tx_busy
);
  import pcs_pkg::*;

  pcs_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       control_q, control_d;
  logic       tx_even_q, tx_even_d;
  logic       rd_q, rd_d;

`ifndef PCS_TX_ERR_PROP_EN
  logic unused_tx_er;
  assign unused_tx_er = tx_er;
`endif

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    control_d = control_q;
    tx_even_d = ~tx_even_q;
    rd_d      = rd_q;

    case (state_q)
      ST_IDLE_K: state_d = ST_IDLE_D;
      ST_IDLE_D: state_d = tx_en ? ST_SOP : ST_IDLE_K;
      ST_SOP,
      ST_DATA:   state_d = tx_en ? ST_DATA : ST_EOP_T;
      ST_EOP_T:  state_d = ST_EOP_R;
      // An /R/ on an even slot needs a second /R/ so idle resumes even.
      ST_EOP_R:  state_d = tx_even_q ? ST_EOP_R : ST_IDLE_K;
      default:   state_d = ST_IDLE_K;
    endcase

    case (state_d)
      ST_IDLE_K: begin
        data_d    = K28_5;
        control_d = 1'b1;
        rd_d      = rd;
      end
      ST_IDLE_D: begin
        data_d    = rd_q ? D5_6 : D16_2;
        control_d = 1'b0;
      end
      ST_SOP: begin
        data_d    = K27_7;
        control_d = 1'b1;
      end
      ST_DATA: begin
        data_d    = txd;
        control_d = 1'b0;
`ifdef PCS_TX_ERR_PROP_EN
        if (tx_er) begin
          data_d    = K30_7;
          control_d = 1'b1;
        end
`endif
      end
      ST_EOP_T: begin
        data_d    = K29_7;
        control_d = 1'b1;
      end
      ST_EOP_R: begin
        data_d    = K23_7;
        control_d = 1'b1;
      end
      default: begin
        data_d    = K28_5;
        control_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE_K;
      data_q    <= K28_5;
      control_q <= 1'b1;
      tx_even_q <= 1'b1;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      control_q <= control_d;
      tx_even_q <= tx_even_d;
      rd_q      <= rd_d;
    end
  end

  assign data    = data_q;
  assign control = control_q;
  assign tx_even = tx_even_q;
  assign tx_busy = state_is_busy(state_q);

endmodule

// File: tb/tb_pcs_tx_ordered_set.sv
// Directed bench for pcs_tx_ordered_set: stimulus pushes expected code-groups
// into a queue, a monitor pops and compares one per clock.
module tb_pcs_tx_ordered_set;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] txd = 8'h00;
  logic       tx_en = 1'b0;
  logic       tx_er = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       control;
  logic       tx_even;
  logic       tx_busy;

  typedef struct packed {
    logic [7:0] data;
    logic       ctl;
    logic       even;
    logic       busy;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    txn = 0;
  logic  exp_even = 1'b1;

  pcs_tx_ordered_set dut (
    .clk(clk), .reset(reset), .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .rd(rd),
    .data(data), .control(control), .tx_even(tx_even), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue the code-group expected after the edge.
  task automatic step(input string tag, input logic rst_n, input logic en, input logic er,
                      input logic [7:0] d, input logic r,
                      input logic [7:0] ed, input logic ec, input logic eb);
    exp_t e;
    @(negedge clk);
    reset = rst_n;
    tx_en = en;
    tx_er = er;
    txd   = d;
    rd    = r;
    exp_even = rst_n ? ~exp_even : 1'b1;
    e.data = ed;
    e.ctl  = ec;
    e.even = exp_even;
    e.busy = eb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        txn++;
        if (data !== e.data || control !== e.ctl || tx_even !== e.even || tx_busy !== e.busy) begin
          errors++;
          $display("FAIL %s: got data=%h ctl=%b even=%b busy=%b, want data=%h ctl=%b even=%b busy=%b",
                   t, data, control, tx_even, tx_busy, e.data, e.ctl, e.even, e.busy);
        end else begin
          $display("txn %0d %s: data=%h ctl=%b even=%b busy=%b ok",
                   txn, t, data, control, tx_even, tx_busy);
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hBC, 1'b1, 1'b0);
    // Idle after release: /I2/ pairs.
    step("idle_d0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    step("idle_k0", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hBC, 1'b1, 1'b0);
    step("idle_d1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    step("idle_k1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hBC, 1'b1, 1'b0);
    // Disparity selects /I1/ versus /I2/; rd held across each K/D pair.
    step("rd0_d",   1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    step("rd1_k",   1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hBC, 1'b1, 1'b0);
    step("rd1_i1",  1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC5, 1'b0, 1'b0);
    step("rd0_k",   1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hBC, 1'b1, 1'b0);
    step("rd0_i2",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    // Frame 1: 8 octets, tx_en rising while IDLE_D shown; /T/ even.
    step("f1_sop",  1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 8'hFB, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step("f1_d55", 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
    step("f1_dD5",  1'b1, 1'b1, 1'b0, 8'hD5, 1'b0, 8'hD5, 1'b0, 1'b1);
    step("f1_dAA",  1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 8'hAA, 1'b0, 1'b1);
    step("f1_t",    1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFD, 1'b1, 1'b1);
    step("f1_r",    1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hF7, 1'b1, 1'b1);
    step("f1_idle", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hBC, 1'b1, 1'b0);
    step("f1_idd",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    // Frame 2: /T/ odd gives two /R/; tx_en during /T/,/R/ ignored.
    step("f2_sop",  1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 8'hFB, 1'b1, 1'b1);
    step("f2_dB2",  1'b1, 1'b1, 1'b0, 8'hB2, 1'b0, 8'hB2, 1'b0, 1'b1);
    step("f2_dC3",  1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 8'hC3, 1'b0, 1'b1);
    step("f2_t",    1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hFD, 1'b1, 1'b1);
    step("f2_r1",   1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 8'hF7, 1'b1, 1'b1);
    step("f2_r2",   1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 8'hF7, 1'b1, 1'b1);
    step("f2_idle", 1'b1, 1'b1, 1'b0, 8'h88, 1'b0, 8'hBC, 1'b1, 1'b0);
    // tx_en already high at IDLE_K: octet dropped through IDLE_D, then /S/.
    step("f3_drop", 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 8'h50, 1'b0, 1'b0);
    step("f3_sop",  1'b1, 1'b1, 1'b0, 8'h9A, 1'b0, 8'hFB, 1'b1, 1'b1);
    step("f3_d01",  1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0, 1'b1);
    step("f3_d02",  1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h02, 1'b0, 1'b1);
`ifdef PCS_TX_ERR_PROP_EN
    step("f3_err",  1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'hFE, 1'b1, 1'b1);
`else
    step("f3_err",  1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h03, 1'b0, 1'b1);
`endif
    step("f3_d04",  1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1);
    // Carrier extension (tx_er without tx_en) has no effect on /T/ /R/.
    step("f3_t",    1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 8'hFD, 1'b1, 1'b1);
    step("f3_r1",   1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 8'hF7, 1'b1, 1'b1);
    step("f3_r2",   1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hF7, 1'b1, 1'b1);
    step("f3_idle", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hBC, 1'b1, 1'b0);
    step("f3_idd",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);
    // Frame 4 aborted by reset mid-data.
    step("f4_sop",  1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 8'hFB, 1'b1, 1'b1);
    step("f4_d11",  1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 8'h11, 1'b0, 1'b1);
    step("f4_rst",  1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 8'hBC, 1'b1, 1'b0);
    // Stored disparity cleared by reset: /I2/ even with rd=1 at release.
    step("rel_i2",  1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h50, 1'b0, 1'b0);
    step("rel_k",   1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hBC, 1'b1, 1'b0);
    step("rel_i1",  1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC5, 1'b0, 1'b0);
    step("end_k",   1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'hBC, 1'b1, 1'b0);
    step("end_i2",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
